bus_tristate_arbiter: RTL

Round-robin arbiter that owns a shared tristate data bus and produces the one-hot output-enable vector for the per-source tristate buffers that drive it. It sits directly upstream of the tristate buffer stage: each bit of `bus_en` connects to one buffer's enable input. It guarantees at most one enabled driver per cycle, inserts a programmable all-off turnaround gap between owners, and force-releases owners that exceed a hold limit.

---
 rtl/bus_tristate_arbiter_pkg.sv | 43 ++++
 rtl/bus_tristate_arbiter_rr_picker.sv | 24 ++
 rtl/bus_tristate_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bus_tristate_arbiter_pkg.sv
// Shared types, constants and the round-robin pick function for the tristate bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam int HOLD_W  = 8;
    localparam int TURN_W  = 2;
    localparam int MAX_SRC = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping modulo n; equivalent to rotate, encode, rotate back.
    function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input logic [3:0] n);
        rr_pick_t   res;
        logic [3:0] pos;
        res.valid = 1'b0;
        res.idx   = 3'd0;
        for (int i = 0; i < MAX_SRC; i++) begin
            pos = {1'b0, ptr} + 4'(i);
            if (pos >= n) begin
                pos = pos - n;
            end else begin
                pos = pos;
            end
            if (!res.valid && (4'(i) < n) && req[pos[2:0]]) begin
                res.valid = 1'b1;
                res.idx   = pos[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_tristate_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest-index requester counting upward from ptr.
import bus_arb_pkg::*;

module rr_picker #(
    parameter  int N_SRC = 4,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    rr_pick_t pick_s;

    // Widen to the package's fixed 8-source form and pick.
    always_comb begin
        pick_s = rr_pick(8'(req), 3'(ptr), 4'(N_SRC));
    end

    assign winner = IDX_W'(pick_s.idx);
    assign valid  = pick_s.valid;

endmodule

// File: rtl/bus_tristate_arbiter.sv
// Round-robin owner of a shared tristate bus: one-hot registered enables, turnaround gap, hold limit.
import bus_arb_pkg::*;

module bus_tristate_arbiter #(
    parameter  int N_SRC    = 4,
    parameter  int TURN_CYC = 1,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] done,
    output logic [N_SRC-1:0] grant,
    output logic [N_SRC-1:0] bus_en,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             timeout
);

    localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};
    localparam logic [N_SRC-1:0] NO_SRC   = {N_SRC{1'b0}};

    arb_state_t        state_r, state_nxt_s;
    logic [IDX_W-1:0]  ptr_r, ptr_nxt_s, owner_nxt_s, pick_idx_s;
    logic [HOLD_W-1:0] hold_r, hold_nxt_s;
    logic [TURN_W-1:0] turn_r, turn_nxt_s;
    logic [N_SRC-1:0]  grant_nxt_s;
    logic              timeout_nxt_s, pick_valid_s, arb_s, expire_s, owner_req_s, owner_done_s;

    rr_picker #(.N_SRC(N_SRC)) u_picker (
        .req    (req),
        .ptr    (ptr_r),
        .winner (pick_idx_s),
        .valid  (pick_valid_s)
    );

    assign owner_req_s  = req[owner];
    assign owner_done_s = done[owner];
    // hold_r counts owned cycles already completed, so the limit hits on the MAX_HOLD-th cycle.
    assign expire_s     = (hold_r >= HOLD_W'(MAX_HOLD - 1));

    // Next-state, counter and output-register values.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant;
        owner_nxt_s   = owner;
        ptr_nxt_s     = ptr_r;
        hold_nxt_s    = hold_r;
        turn_nxt_s    = turn_r;
        timeout_nxt_s = 1'b0;
        arb_s         = 1'b0;
        case (state_r)
            IDLE: begin
                arb_s = pick_valid_s;
            end
            OWN: begin
                if (owner_done_s || !owner_req_s || expire_s) begin
                    state_nxt_s   = TURN;
                    grant_nxt_s   = NO_SRC;
                    turn_nxt_s    = TURN_W'(TURN_CYC);
                    timeout_nxt_s = expire_s && owner_req_s && !owner_done_s;
                end else if (hold_r != {HOLD_W{1'b1}}) begin
                    hold_nxt_s = hold_r + 8'd1;
                end else begin
                    hold_nxt_s = hold_r;
                end
            end
            TURN: begin
                if (turn_r <= 2'd1) begin
                    state_nxt_s = IDLE;
                    arb_s       = pick_valid_s;
                end else begin
                    turn_nxt_s = turn_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = NO_SRC;
            end
        endcase
        // The pointer already sits past the previous owner, so it is naturally lowest priority.
        if (arb_s) begin
            state_nxt_s = OWN;
            grant_nxt_s = ONE_HOT0 << pick_idx_s;
            owner_nxt_s = pick_idx_s;
            hold_nxt_s  = {HOLD_W{1'b0}};
            ptr_nxt_s   = (pick_idx_s == IDX_W'(N_SRC - 1)) ? {IDX_W{1'b0}}
                                                             : pick_idx_s + IDX_W'(1);
        end else begin
            ptr_nxt_s = ptr_nxt_s;
        end
    end

    // State, counters and all outputs; reset drops every enable immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            grant   <= NO_SRC;
            bus_en  <= NO_SRC;
            owner   <= {IDX_W{1'b0}};
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr_r   <= {IDX_W{1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
            turn_r  <= {TURN_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            grant   <= grant_nxt_s;
            bus_en  <= grant_nxt_s;
            owner   <= owner_nxt_s;
            busy    <= |grant_nxt_s;
            timeout <= timeout_nxt_s;
            ptr_r   <= ptr_nxt_s;
            hold_r  <= hold_nxt_s;
            turn_r  <= turn_nxt_s;
        end
    end

endmodule
